// File: rtl/load_store_unit.sv
// load_store_unit: per-thread LDR/STR engine with a valid/ready memory handshake.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   enable                thread active; low freezes all state
//   core_state            core phase (REQUEST=3'b011, UPDATE=3'b110)
//   decoded_mem_*_en      LDR / STR decode (read wins if both set)
//   rs, rt                address operand, store-data operand
//   mem_read_*            read request channel to the memory controller
//   mem_write_*           write request channel to the memory controller
//   lsu_state             IDLE=0, REQUESTING=1, WAITING=2, DONE=3
//   lsu_out               last loaded value
module load_store_unit #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [2:0]           core_state,
    input  logic                 decoded_mem_read_en,
    input  logic                 decoded_mem_write_en,
    input  logic [DATA_BITS-1:0] rs,
    input  logic [DATA_BITS-1:0] rt,
    output logic                 mem_read_valid,
    output logic [ADDR_BITS-1:0] mem_read_address,
    input  logic                 mem_read_ready,
    input  logic [DATA_BITS-1:0] mem_read_data,
    output logic                 mem_write_valid,
    output logic [ADDR_BITS-1:0] mem_write_address,
    output logic [DATA_BITS-1:0] mem_write_data,
    input  logic                 mem_write_ready,
    output logic [1:0]           lsu_state,
    output logic [DATA_BITS-1:0] lsu_out
);
    typedef enum logic [1:0] {IDLE, REQUESTING, WAITING, DONE} state_t;
    localparam logic [2:0] REQUEST = 3'b011;
    localparam logic [2:0] UPDATE  = 3'b110;
    state_t               state_q, state_d;
    logic                 rd_valid_q, rd_valid_d, wr_valid_q, wr_valid_d;
    logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic [DATA_BITS-1:0] wr_data_q, wr_data_d, lsu_out_q, lsu_out_d;
    always_comb begin
        state_d    = state_q;
        rd_valid_d = rd_valid_q;
        wr_valid_d = wr_valid_q;
        rd_addr_d  = rd_addr_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        lsu_out_d  = lsu_out_q;
        if (enable) begin
            case (state_q)
                IDLE: begin
                    if (core_state == REQUEST && (decoded_mem_read_en || decoded_mem_write_en))
                        state_d = REQUESTING;
                end
                REQUESTING: begin
                    if (decoded_mem_read_en) begin
                        rd_valid_d = 1'b1;
                        rd_addr_d  = rs[ADDR_BITS-1:0];
                    end else if (decoded_mem_write_en) begin
                        wr_valid_d = 1'b1;
                        wr_addr_d  = rs[ADDR_BITS-1:0];
                        wr_data_d  = rt;
                    end
                    state_d = WAITING;
                end
                WAITING: begin
                    // The pending valid identifies the operation, so ready on the idle channel is ignored.
                    if (rd_valid_q && mem_read_ready) begin
                        rd_valid_d = 1'b0;
                        lsu_out_d  = mem_read_data;
                        state_d    = DONE;
                    end else if (wr_valid_q && mem_write_ready) begin
                        wr_valid_d = 1'b0;
                        state_d    = DONE;
                    end
                end
                DONE: state_d = core_state == UPDATE ? IDLE : DONE;
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rd_valid_q <= 1'b0;
            wr_valid_q <= 1'b0;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            lsu_out_q  <= '0;
        end else begin
            state_q    <= state_d;
            rd_valid_q <= rd_valid_d;
            wr_valid_q <= wr_valid_d;
            rd_addr_q  <= rd_addr_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            lsu_out_q  <= lsu_out_d;
        end
    end
    assign lsu_state         = state_q;
    assign mem_read_valid    = rd_valid_q;
    assign mem_read_address  = rd_addr_q;
    assign mem_write_valid   = wr_valid_q;
    assign mem_write_address = wr_addr_q;
    assign mem_write_data    = wr_data_q;
    assign lsu_out           = lsu_out_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench for load_store_unit with a memory responder and reference model.
module tb_load_store_unit;
    logic       clk = 1'b0;
    logic       rst_n, enable, rd_en, wr_en;
    logic [2:0] core_state;
    logic [7:0] rs, rt, mem_read_data;
    logic       mem_read_ready, mem_write_ready;
    logic       mem_read_valid, mem_write_valid;
    logic [7:0] mem_read_address, mem_write_address, mem_write_data, lsu_out;
    logic [1:0] lsu_state;

    load_store_unit #(.ADDR_BITS(8), .DATA_BITS(8)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .core_state(core_state),
        .decoded_mem_read_en(rd_en), .decoded_mem_write_en(wr_en), .rs(rs), .rt(rt),
        .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
        .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
        .lsu_state(lsu_state), .lsu_out(lsu_out)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] REQ = 3'b011, WAITC = 3'b100, UPD = 3'b110;

    typedef struct {
        bit         is_read;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] lsu;
    } exp_t;

    exp_t       exp_q[$];
    int         errors = 0, checks = 0;
    logic [7:0] ref_mem[256];
    logic [7:0] resp_mem[256];
    logic [7:0] last_load;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted handshake, then checks the completion one cycle later.
    bit   pend = 0;
    exp_t cur;
    always @(negedge clk) begin
        if (pend) begin
            chk("done_state", 32'(lsu_state), 32'd3);
            chk("lsu_out", 32'(lsu_out), 32'(cur.lsu));
            pend = 0;
        end
        if (rst_n && enable && ((mem_read_valid && mem_read_ready) || (mem_write_valid && mem_write_ready))) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_handshake: got rv=%0b wv=%0b required none", mem_read_valid, mem_write_valid);
            end else begin
                cur = exp_q.pop_front();
                chk("kind_read", 32'(mem_read_valid && mem_read_ready), 32'(cur.is_read));
                chk("addr", 32'(cur.is_read ? mem_read_address : mem_write_address), 32'(cur.addr));
                if (!cur.is_read) chk("wdata", 32'(mem_write_data), 32'(cur.wdata));
                pend = 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_state"}, 32'(lsu_state), 32'd0);
        chk({tag, "_rv"}, 32'(mem_read_valid), 32'd0);
        chk({tag, "_wv"}, 32'(mem_write_valid), 32'd0);
        chk({tag, "_ra"}, 32'(mem_read_address), 32'd0);
        chk({tag, "_wa"}, 32'(mem_write_address), 32'd0);
        chk({tag, "_wd"}, 32'(mem_write_data), 32'd0);
        chk({tag, "_lsu"}, 32'(lsu_out), 32'd0);
    endtask

    // Issue REQUEST and check the two-edge launch; leaves the unit in WAITING.
    task automatic launch(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] d, input bit track);
        exp_t e;
        enable = 1; core_state = REQ; rd_en = rd; wr_en = wr; rs = a; rt = d;
        if (track) begin
            e.is_read = rd; e.addr = a; e.wdata = d;
            if (rd) last_load = ref_mem[a];
            else ref_mem[a] = d;
            e.lsu = last_load;
            exp_q.push_back(e);
        end
        step();
        chk("req_state", 32'(lsu_state), 32'd1);
        chk("valid_early", 32'({mem_read_valid, mem_write_valid}), 32'd0);
        core_state = WAITC;
        step();
        chk("wait_state", 32'(lsu_state), 32'd2);
        chk("rv_launch", 32'(mem_read_valid), 32'(rd));
        chk("wv_launch", 32'(mem_write_valid), 32'(!rd));
        rd_en = 0; wr_en = 0; rs = 8'($urandom); rt = 8'($urandom);
    endtask

    task automatic txn(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] d,
                       input int delay, input bit freeze);
        launch(rd, wr, a, d, 1);
        if (freeze) begin
            enable = 0;
            if (rd) begin mem_read_ready = 1; mem_read_data = resp_mem[mem_read_address]; end
            else begin mem_write_ready = 1; resp_mem[mem_write_address] = mem_write_data; end
            repeat (5) begin
                step();
                chk("frz_state", 32'(lsu_state), 32'd2);
                chk("frz_valid", 32'(rd ? mem_read_valid : mem_write_valid), 32'd1);
            end
            enable = 1;
        end else begin
            repeat (delay) begin
                if (rd) mem_write_ready = 1'($urandom); else mem_read_ready = 1'($urandom);
                mem_read_data = 8'($urandom);
                step();
                chk("hold_state", 32'(lsu_state), 32'd2);
            end
            if (rd) begin mem_read_ready = 1; mem_write_ready = 0; mem_read_data = resp_mem[mem_read_address]; end
            else begin mem_write_ready = 1; mem_read_ready = 0; resp_mem[mem_write_address] = mem_write_data; end
        end
        step();
        mem_read_ready = 0; mem_write_ready = 0; mem_read_data = 8'($urandom);
        // A new REQUEST while DONE must not start another request.
        core_state = REQ; rd_en = 1'($urandom); wr_en = 1;
        repeat ($urandom_range(1, 2)) begin
            step();
            chk("done_hold", 32'(lsu_state), 32'd3);
            chk("done_novalid", 32'({mem_read_valid, mem_write_valid}), 32'd0);
        end
        core_state = UPD; rd_en = 0; wr_en = 0;
        step();
        chk("update_idle", 32'(lsu_state), 32'd0);
        core_state = 3'b000;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 8'($urandom);
            resp_mem[i] = ref_mem[i];
        end
        last_load = 0;
        rst_n = 0; enable = 0; core_state = 0; rd_en = 0; wr_en = 0; rs = 0; rt = 0;
        mem_read_ready = 0; mem_write_ready = 0; mem_read_data = 0;
        step(); step();
        rst_n = 1;
        chk_reset_outputs("rst");
        // Disabled thread ignores REQUEST.
        core_state = REQ; rd_en = 1;
        step(); step();
        chk("dis_state", 32'(lsu_state), 32'd0);
        chk("dis_rv", 32'(mem_read_valid), 32'd0);
        rd_en = 0; core_state = 0;
        ref_mem[8'h12] = 8'hA5; resp_mem[8'h12] = 8'hA5;
        txn(1, 0, 8'h12, 8'h00, 2, 0);
        txn(0, 1, 8'h40, 8'h7E, 1, 0);
        txn(1, 1, 8'h55, 8'h99, 1, 0);
        txn(1, 0, 8'h77, 8'h00, 0, 1);
        ref_mem[8'h01] = 8'h11; resp_mem[8'h01] = 8'h11;
        ref_mem[8'h02] = 8'h22; resp_mem[8'h02] = 8'h22;
        txn(1, 0, 8'h01, 8'h00, 0, 0);
        txn(1, 0, 8'h02, 8'h00, 0, 0);
        // Reset while waiting on a read abandons it.
        launch(1, 0, 8'h33, 8'h00, 0);
        rst_n = 0;
        step();
        rst_n = 1;
        last_load = 0;
        chk_reset_outputs("midrst");
        mem_read_ready = 1; mem_read_data = 8'hEE;
        repeat (2) step();
        chk("late_ready_state", 32'(lsu_state), 32'd0);
        chk("late_ready_lsu", 32'(lsu_out), 32'd0);
        mem_read_ready = 0;
        for (int n = 0; n < 40; n++) begin
            bit r;
            r = 1'($urandom);
            txn(r, r ? 1'($urandom) : 1'b1, 8'($urandom), 8'($urandom), $urandom_range(0, 4), ($urandom % 8) == 0);
        end
        step(); step();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
